// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return !op[0];
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// shift-subtract divide on the {acc_hi, acc_lo} pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  input  logic             is_div,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             q_bit
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl  = {acc_hi, acc_lo[WIDTH-1]};
    diff = shl - {1'b0, opnd};
    if (is_div) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      q_bit  = !diff[WIDTH];
      nxt_hi = q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end else begin
      q_bit  = 1'b0;
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divides stay iterative).
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWrEn,
  input  logic             LoWrEn,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_q;
  logic [WIDTH-1:0] lo_nxt;
  op_e              op_in;
  logic             in_signed, in_div, a_neg, b_neg, start_ok;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi (acc_hi_q),
    .acc_lo (acc_lo_q),
    .opnd   (opnd_q),
    .is_div (op_is_div(op_q)),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo),
    .q_bit  (step_q)
  );

  assign lo_nxt = step_lo | {{(WIDTH-1){1'b0}}, step_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod      = '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = '0;
`endif

    op_in     = op_e'(Op);
    in_signed = op_is_signed(op_in);
    in_div    = op_is_div(op_in);
    a_neg     = in_signed && SrcA[WIDTH-1];
    b_neg     = in_signed && SrcB[WIDTH-1];
    a_mag     = a_neg ? -SrcA : SrcA;
    b_mag     = b_neg ? -SrcB : SrcB;
    start_ok  = Start && (state_q != ST_RUN);

    unique case (state_q)
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = lo_nxt;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = ST_DONE;
          if (op_is_div(op_q)) begin
            lo_d = dz_q ? {WIDTH{DIV0_QUOT[0]}} : (neg_q ? -lo_nxt : lo_nxt);
            hi_d = rem_neg_q ? -step_hi : step_hi;
          end else begin
            prod = {step_hi, lo_nxt};
            if (neg_q) prod = -prod;
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: begin
        if (start_ok) begin
          op_d     = op_in;
          state_d  = ST_RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          dz_d     = in_div && (SrcB == '0);
          neg_d    = a_neg ^ b_neg;
          if (in_div && (SrcB == '0)) begin
            // Raw dividend through an all-ones quotient leaves SrcA as remainder.
            acc_lo_d  = SrcA;
            opnd_d    = '0;
            neg_d     = 1'b0;
            rem_neg_d = 1'b0;
          end else if (in_div) begin
            acc_lo_d  = a_mag;
            opnd_d    = b_mag;
            rem_neg_d = a_neg;
          end else begin
            acc_lo_d  = b_mag;
            opnd_d    = a_mag;
            rem_neg_d = 1'b0;
          end
`ifdef MULDIV_FAST_MUL_EN
          if (!in_div) begin
            fast_prod = a_mag * b_mag;
            if (a_neg ^ b_neg) fast_prod = -fast_prod;
            {hi_d, lo_d} = fast_prod;
            state_d      = ST_DONE;
          end
`endif
        end else begin
          state_d = ST_IDLE;
          if (HiWrEn) hi_d = WrData;
          if (LoWrEn) lo_d = WrData;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy    = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);
  assign DivZero = (state_q == ST_DONE) && dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus pushes expected HI/LO/DivZero and
// Done cycle; a negedge monitor pops and compares on every Done pulse.
module tb_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        Start, HiWrEn, LoWrEn;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WrData;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  muldiv dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWrEn(HiWrEn), .LoWrEn(LoWrEn), .WrData(WrData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst && Done) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", Hi, e.hi);
        chk("lo", Lo, e.lo);
        chk("divzero", {31'b0, DivZero}, {31'b0, e.dz});
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", {31'b0, Busy}, 32'd0);
      end
    end
  end

  // Called at posedge+#1; leaves Start low at posedge+#1 one cycle later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t e;
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + 33;
    sb.push_back(e);
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 120; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL timeout: got %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; HiWrEn = 1'b0; LoWrEn = 1'b0;
    Op = 2'd0; SrcA = '0; SrcB = '0; WrData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_done", {31'b0, Done}, 32'd0);
    chk("rst_dz", {31'b0, DivZero}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(2'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    chk("busy_run", {31'b0, Busy}, 32'd1);
    drain();
    issue(2'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0); drain();
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); drain();
    issue(2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0); drain();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0); drain();
    issue(2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1); drain();
    issue(2'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1); drain();

    // MTHI at idle, then MTLO during RUN must be dropped.
    HiWrEn = 1'b1; WrData = 32'h1234;
    @(posedge clk); #1;
    HiWrEn = 1'b0;
    chk("mthi", Hi, 32'h1234);
    chk("lo_hold", Lo, 32'hFFFFFFFF);
    issue(2'd1, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    LoWrEn = 1'b1; WrData = 32'hDEAD;
    @(posedge clk); #1;
    LoWrEn = 1'b0;
    chk("mtlo_dropped", Lo, 32'hFFFFFFFF);
    chk("hi_hold_run", Hi, 32'h1234);
    drain();

    // Start wins over a same-cycle MTLO.
    LoWrEn = 1'b1; WrData = 32'h5555;
    issue(2'd1, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0);
    LoWrEn = 1'b0;
    chk("start_wins", Lo, 32'd4);
    drain();

    // Start while busy is ignored.
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    Start = 1'b1; Op = 2'd1; SrcA = 32'd3; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    drain();
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back: second Start issued in the Done cycle.
    issue(2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (Done) break;
      @(posedge clk); #1;
    end
    issue(2'd3, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);
    drain();

    LoWrEn = 1'b1; WrData = 32'hABCD;
    @(posedge clk); #1;
    LoWrEn = 1'b0;
    chk("mtlo", Lo, 32'hABCD);

    // Reset ten cycles into a DIVU aborts it without a Done pulse.
    Start = 1'b1; Op = 2'd3; SrcA = 32'd100; SrcB = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'b0, Busy}, 32'd0);
    chk("abort_hi", Hi, 32'd0);
    chk("abort_lo", Lo, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
